note_sequencer: RTL and testbench

Consumes the four one-cycle button pulses from the button pulse generator and turns them into a small recorded melody. In EDIT mode the player picks a pitch, appends notes to an internal song buffer and starts playback. In PLAY mode the buffer is stepped through at a fixed note duration and looped. The outputs drive the tone generator (pitch index plus enable) and the status display.

---
 rtl/note_sequencer.sv | 141 ++++++++++++++
 tb/tb_note_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// Button-driven melody recorder: EDIT mode selects pitches and appends them to a
// small song buffer, PLAY mode loops the buffer at a fixed note duration.
//
// state | meaning
// EDIT  | pitch select and note append; tone disabled
// PLAY  | buffer stepped every STEP_CYCLES cycles and looped; tone enabled
module note_sequencer #(
    parameter int DEPTH       = 16,
    parameter int NOTE_W      = 4,
    parameter int STEP_CYCLES = 12_500_000,
    localparam int LEN_W      = $clog2(DEPTH + 1),
    localparam int IDX_W      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [3:0]        button_pulse,
    output logic [NOTE_W-1:0] cur_note,
    output logic              note_valid,
    output logic              playing,
    output logic [IDX_W-1:0]  play_idx,
    output logic [LEN_W-1:0]  song_len,
    output logic              full
);

    localparam int               TMR_W    = $clog2(STEP_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(STEP_CYCLES - 1);
    localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(DEPTH);

    typedef enum logic {
        EDIT = 1'b0,
        PLAY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [NOTE_W-1:0]  sel_pitch_q, sel_pitch_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [IDX_W-1:0]   play_idx_q, play_idx_d;
    logic [LEN_W-1:0]   song_len_q, song_len_d;
    logic               full_q, full_d;
    logic [NOTE_W-1:0]  cur_note_q, cur_note_d;
    logic               playing_q, playing_d;
    logic               note_valid_q, note_valid_d;

    logic [NOTE_W-1:0]  mem_q [DEPTH];
    logic               mem_we;
    logic [IDX_W-1:0]   mem_waddr;
    logic [NOTE_W-1:0]  mem_wdata;
    logic               idx_last;

    assign idx_last = (LEN_W'(play_idx_q) == song_len_q - LEN_W'(1));

    always_comb begin
        state_d     = state_q;
        sel_pitch_d = sel_pitch_q;
        timer_d     = timer_q;
        play_idx_d  = play_idx_q;
        song_len_d  = song_len_q;
        mem_we      = 1'b0;
        mem_waddr   = song_len_q[IDX_W-1:0];
        mem_wdata   = sel_pitch_q;

        unique case (state_q)
            EDIT: begin
                if (button_pulse[3] && song_len_q != '0) begin
                    state_d    = PLAY;
                    play_idx_d = '0;
                    timer_d    = TMR_LOAD;
                end else begin
                    // Store uses the pitch from before any same-cycle change.
                    if (button_pulse[2] && !full_q) begin
                        mem_we     = 1'b1;
                        song_len_d = song_len_q + LEN_W'(1);
                    end
                    if (button_pulse[0] && !button_pulse[1] && sel_pitch_q != '1) begin
                        sel_pitch_d = sel_pitch_q + NOTE_W'(1);
                    end else if (button_pulse[1] && !button_pulse[0] && sel_pitch_q != '0) begin
                        sel_pitch_d = sel_pitch_q - NOTE_W'(1);
                    end
                end
            end
            PLAY: begin
                if (button_pulse[3]) begin
                    state_d    = EDIT;
                    timer_d    = '0;
                    play_idx_d = '0;
                end else if (timer_q == '0) begin
                    timer_d    = TMR_LOAD;
                    play_idx_d = idx_last ? '0 : play_idx_q + IDX_W'(1);
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: state_d = EDIT;
        endcase

        playing_d    = (state_d == PLAY);
        note_valid_d = (state_d == PLAY);
        full_d       = (song_len_d == LEN_FULL);
        // Buffer is frozen in PLAY, so reading mem_q with the next index is safe.
        cur_note_d   = (state_d == PLAY) ? mem_q[play_idx_d] : sel_pitch_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= EDIT;
            sel_pitch_q  <= '0;
            timer_q      <= '0;
            play_idx_q   <= '0;
            song_len_q   <= '0;
            full_q       <= 1'b0;
            cur_note_q   <= '0;
            playing_q    <= 1'b0;
            note_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_pitch_q  <= sel_pitch_d;
            timer_q      <= timer_d;
            play_idx_q   <= play_idx_d;
            song_len_q   <= song_len_d;
            full_q       <= full_d;
            cur_note_q   <= cur_note_d;
            playing_q    <= playing_d;
            note_valid_q <= note_valid_d;
        end
    end

    // Song storage is deliberately not reset; song_len gates what is reachable.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign cur_note   = cur_note_q;
    assign note_valid = note_valid_q;
    assign playing    = playing_q;
    assign play_idx   = play_idx_q;
    assign song_len   = song_len_q;
    assign full       = full_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: directed table, hand-written corner
// sequences and randomized pulses against a queue-based melody model.
module tb_note_sequencer;

    localparam int DEPTH = 4;
    localparam int NOTE_W = 4;
    localparam int STEP = 4;
    localparam int LEN_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PMAX = (1 << NOTE_W) - 1;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [3:0]        button_pulse = 4'd0;
    logic [NOTE_W-1:0] cur_note;
    logic              note_valid;
    logic              playing;
    logic [IDX_W-1:0]  play_idx;
    logic [LEN_W-1:0]  song_len;
    logic              full;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: melody as a queue, playback position as index + age.
    int  m_song[$];
    int  m_sel;
    bit  m_play;
    int  m_idx;
    int  m_age;

    note_sequencer #(.DEPTH(DEPTH), .NOTE_W(NOTE_W), .STEP_CYCLES(STEP)) dut (
        .clk(clk), .reset_n(reset_n), .button_pulse(button_pulse),
        .cur_note(cur_note), .note_valid(note_valid), .playing(playing),
        .play_idx(play_idx), .song_len(song_len), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] pulse;
        int         reps;
        int         exp_note;
        int         exp_len;
        int         exp_full;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_song.delete();
        m_sel = 0;
        m_play = 0;
        m_idx = 0;
        m_age = 0;
    endfunction

    function automatic void model_step(input logic [3:0] p);
        if (!m_play) begin
            if (p[3] && m_song.size() > 0) begin
                m_play = 1;
                m_idx = 0;
                m_age = 0;
            end else begin
                if (p[2] && m_song.size() < DEPTH) m_song.push_back(m_sel);
                if (p[0] && !p[1]) m_sel = (m_sel < PMAX) ? m_sel + 1 : PMAX;
                if (p[1] && !p[0]) m_sel = (m_sel > 0) ? m_sel - 1 : 0;
            end
        end else if (p[3]) begin
            m_play = 0;
            m_idx = 0;
        end else begin
            m_age++;
            if (m_age == STEP) begin
                m_age = 0;
                m_idx = (m_idx + 1) % m_song.size();
            end
        end
    endfunction

    task automatic check_model();
        chk("model_cur_note", 32'(cur_note), m_play ? m_song[m_idx] : m_sel);
        chk("model_playing", 32'(playing), 32'(m_play));
        chk("model_note_valid", 32'(note_valid), 32'(m_play));
        chk("model_play_idx", 32'(play_idx), m_idx);
        chk("model_song_len", 32'(song_len), m_song.size());
        chk("model_full", 32'(full), (m_song.size() == DEPTH) ? 1 : 0);
    endtask

    // Called at posedge+1; returns at the next posedge+1 with outputs checked.
    task automatic apply(input logic [3:0] p);
        button_pulse = p;
        @(posedge clk);
        model_step(p);
        #1;
        button_pulse = 4'd0;
        check_model();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        chk("rst_playing", 32'(playing), 0);
        chk("rst_note_valid", 32'(note_valid), 0);
        chk("rst_song_len", 32'(song_len), 0);
        chk("rst_play_idx", 32'(play_idx), 0);
        chk("rst_cur_note", 32'(cur_note), 0);
        chk("rst_full", 32'(full), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        check_model();
    endtask

    vec_t vecs[$];

    initial begin
        logic [3:0] p;

        vecs.push_back('{4'b0001, 3, 3, 0, 0});
        vecs.push_back('{4'b0100, 1, 3, 1, 0});
        vecs.push_back('{4'b0010, 1, 2, 1, 0});
        vecs.push_back('{4'b0100, 1, 2, 2, 0});

        model_reset();
        #3;
        do_reset();

        // Store two notes: 3 then 2
        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++) apply(vecs[i].pulse);
            chk("tbl_cur_note", 32'(cur_note), vecs[i].exp_note);
            chk("tbl_song_len", 32'(song_len), vecs[i].exp_len);
            chk("tbl_full", 32'(full), vecs[i].exp_full);
            chk("tbl_playing", 32'(playing), 0);
        end

        // Playback and wrap: 3 for 4 cycles, 2 for 4 cycles, then 3 again
        apply(4'b1000);
        chk("play_playing", 32'(playing), 1);
        chk("play_valid", 32'(note_valid), 1);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) apply(4'b0000);
            chk("play_idx_seq", 32'(play_idx), (k / 4) % 2);
            chk("play_note_seq", 32'(cur_note), ((k / 4) % 2 == 1) ? 2 : 3);
        end
        apply(4'b0111);
        chk("play_ignore_btn", 32'(song_len), 2);
        apply(4'b1000);
        chk("stop_playing", 32'(playing), 0);
        chk("stop_note", 32'(cur_note), 2);
        chk("stop_idx", 32'(play_idx), 0);

        // Stop pulse on the same edge as a step: stop wins
        apply(4'b1000);
        for (int k = 0; k < 3; k++) apply(4'b0000);
        apply(4'b1000);
        chk("stop_on_step_idx", 32'(play_idx), 0);
        chk("stop_on_step_play", 32'(playing), 0);

        // Full buffer at pitch 7
        do_reset();
        for (int k = 0; k < 7; k++) apply(4'b0001);
        for (int k = 0; k < 5; k++) apply(4'b0100);
        chk("full_len", 32'(song_len), 4);
        chk("full_flag", 32'(full), 1);
        chk("full_pitch", 32'(cur_note), 7);
        apply(4'b1000);
        for (int k = 0; k < 4 * STEP; k++) begin
            chk("full_play_note", 32'(cur_note), 7);
            chk("full_play_idx", 32'(play_idx), k / STEP);
            apply(4'b0000);
        end
        chk("full_wrap_idx", 32'(play_idx), 0);
        apply(4'b1000);

        // Saturation and empty start
        do_reset();
        for (int k = 0; k < 20; k++) apply(4'b0001);
        chk("sat_hi", 32'(cur_note), 15);
        for (int k = 0; k < 20; k++) apply(4'b0010);
        chk("sat_lo", 32'(cur_note), 0);
        apply(4'b1000);
        chk("empty_play", 32'(playing), 0);
        for (int k = 0; k < 5; k++) apply(4'b0001);
        apply(4'b0011);
        chk("both_pitch", 32'(cur_note), 5);
        apply(4'b1101);
        chk("empty_play_store", 32'(song_len), 1);
        chk("empty_play_pitch", 32'(cur_note), 6);

        // Single-note song holds index 0
        apply(4'b1000);
        for (int k = 0; k < 2 * STEP + 1; k++) begin
            chk("single_idx", 32'(play_idx), 0);
            chk("single_note", 32'(cur_note), 5);
            apply(4'b0000);
        end

        // Reset mid-play, asynchronous
        reset_n = 1'b0;
        #2;
        chk("async_playing", 32'(playing), 0);
        chk("async_valid", 32'(note_valid), 0);
        chk("async_len", 32'(song_len), 0);
        chk("async_idx", 32'(play_idx), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        apply(4'b1000);
        chk("after_rst_play", 32'(playing), 0);

        // Randomized pulses against the model
        for (int seg = 0; seg < 4; seg++) begin
            do_reset();
            for (int k = 0; k < 600; k++) begin
                p = 4'd0;
                p[0] = ($urandom_range(0, 2) == 0);
                p[1] = ($urandom_range(0, 3) == 0);
                p[2] = ($urandom_range(0, 5) == 0);
                p[3] = ($urandom_range(0, 24) == 0);
                apply(p);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
